sys_reg_array_dbuf: RTL and testbench



---
 rtl/sys_reg_array_dbuf.sv | 109 ++++++++++
 tb/tb_sys_reg_array_dbuf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_reg_array_dbuf.sv
// rtl/sys_reg_array_dbuf.sv - double-buffered register array on the system bus
// Bus writes land in a shadow bank; a commit copies it to the active bank in one edge.
module sys_reg_array_dbuf #(
  parameter int DW = 32,
  parameter int RN = 8,
  parameter int RL = (RN > 1) ? $clog2(RN) : 1,
  parameter logic [RN*DW-1:0] RST_VAL = '0,
  parameter logic [RN*DW-1:0] PLS_MSK = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      sys_addr,
  input  logic [31:0]      sys_wdata,
  input  logic [3:0]       sys_sel,
  input  logic             sys_wen,
  input  logic             sys_ren,
  output logic [31:0]      sys_rdata,
  output logic             sys_ack,
  output logic             sys_err,
  input  logic             trig_i,
  output logic [RN*DW-1:0] val,
  output logic             upd_o
);

  typedef logic [RN-1:0][DW-1:0] bank_t;
  localparam bank_t RST_B = RST_VAL;
  localparam bank_t PLS_B = PLS_MSK;

  bank_t         sh_q, act_q, sh_n;
  logic          armed_q, pend_q;
  logic [7:0]    cnt_q;
  logic [RL-1:0] idx;
  logic [1:0]    region;
  logic          acc, in_rng, err_c, sh_wr, ctl_wr, commit, revert;
  logic [31:0]   rd;
  logic [DW-1:0] wmask;
  logic          unused;

  assign idx    = sys_addr[2 +: RL];
  assign region = sys_addr[RL+2 +: 2];
  assign val    = act_q;
  assign unused = ^{sys_addr, sys_wdata};

  always_comb begin
    acc    = sys_wen | sys_ren;
    in_rng = 32'(idx) < 32'(RN);
    case (region)
      2'd0:    err_c = !in_rng;
      2'd1:    err_c = !in_rng || sys_wen;
      2'd2:    err_c = (idx != '0);
      default: err_c = 1'b1;
    endcase
    sh_wr  = sys_wen && (region == 2'd0) && !err_c;
    ctl_wr = sys_wen && (region == 2'd2) && !err_c;
    commit = (ctl_wr && sys_wdata[0]) || (trig_i && armed_q);
    revert = ctl_wr && sys_wdata[3] && !commit;

    // Read data reflects state before any same-cycle write.
    rd = '0;
    if (!err_c) begin
      case (region)
        2'd0:    rd[DW-1:0] = sh_q[idx];
        2'd1:    rd[DW-1:0] = act_q[idx];
        2'd2:    rd = {16'h0, cnt_q, 6'h0, armed_q, pend_q};
        default: rd = '0;
      endcase
    end

    for (int k = 0; k < DW; k++) wmask[k] = sys_sel[k/8];

    // A new bus write lands on top of whatever the commit/revert left in shadow.
    sh_n = sh_q;
    if (revert) sh_n = act_q;
    if (commit) sh_n = (sh_q & ~PLS_B) | (RST_B & PLS_B);
    if (sh_wr)  sh_n[idx] = (sh_n[idx] & ~wmask) | (sys_wdata[DW-1:0] & wmask);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q      <= RST_B;
      act_q     <= RST_B;
      armed_q   <= 1'b0;
      pend_q    <= 1'b0;
      cnt_q     <= 8'h0;
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
      upd_o     <= 1'b0;
    end else begin
      sys_ack <= acc;
      sys_err <= acc && err_c;
      if (sys_ren) sys_rdata <= rd;
      sh_q  <= sh_n;
      // Pulse bits fall back to reset value on every non-commit edge.
      act_q <= commit ? sh_q : ((act_q & ~PLS_B) | (RST_B & PLS_B));
      if (sh_wr)
        pend_q <= 1'b1;
      else if (commit || (ctl_wr && sys_wdata[3]))
        pend_q <= 1'b0;
      if (commit || (ctl_wr && sys_wdata[2]))
        armed_q <= 1'b0;
      else if (ctl_wr && sys_wdata[1])
        armed_q <= 1'b1;
      if (commit) cnt_q <= cnt_q + 8'd1;
      upd_o <= commit;
    end
  end

endmodule

// File: tb/tb_sys_reg_array_dbuf.sv
// tb/tb_sys_reg_array_dbuf.sv - directed self-checking bench for sys_reg_array_dbuf
module tb_sys_reg_array_dbuf;

  localparam int DW = 32;
  localparam int RN = 6;
  localparam logic [RN*DW-1:0] RST = {64'h0, 32'hDEADBEEF, 64'h0, 32'h11111111};
  localparam logic [RN*DW-1:0] PLS = {128'h0, 32'h1, 32'h0};
  localparam logic [31:0] CTL = 32'h40;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [31:0]      sys_addr = '0;
  logic [31:0]      sys_wdata = '0;
  logic [3:0]       sys_sel = '0;
  logic             sys_wen = 1'b0;
  logic             sys_ren = 1'b0;
  logic [31:0]      sys_rdata;
  logic             sys_ack;
  logic             sys_err;
  logic             trig_i = 1'b0;
  logic [RN*DW-1:0] val;
  logic             upd_o;

  int total = 0;
  int bad = 0;

  sys_reg_array_dbuf #(.DW(DW), .RN(RN), .RST_VAL(RST), .PLS_MSK(PLS)) dut (
    .clk(clk), .rstn(rstn), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_sel(sys_sel), .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_ack(sys_ack), .sys_err(sys_err), .trig_i(trig_i), .val(val), .upd_o(upd_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sh_a(input int i);
    return 32'(i) << 2;
  endfunction

  function automatic logic [31:0] act_a(input int i);
    return 32'h20 | (32'(i) << 2);
  endfunction

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic t, output logic ack, output logic err);
    @(posedge clk); #1;
    sys_addr = a; sys_wdata = d; sys_sel = s; sys_wen = 1'b1; trig_i = t;
    @(posedge clk); #1;
    sys_wen = 1'b0; trig_i = 1'b0;
    ack = sys_ack; err = sys_err;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic ack, output logic err);
    @(posedge clk); #1;
    sys_addr = a; sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_ren = 1'b0;
    d = sys_rdata; ack = sys_ack; err = sys_err;
  endtask

  task automatic test_reset;
    logic [RN*DW-1:0] rv;
    logic [31:0] d;
    logic a, e;
    rv = RST;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    total++; if (val !== RST) begin bad++; $display("FAIL reset_val got=%h want=%h", val, RST); end
    total++; if ({sys_ack, sys_err, upd_o} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {sys_ack, sys_err, upd_o}); end
    total++; if (sys_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", sys_rdata); end
    for (int i = 0; i < RN; i++) begin
      bus_read(sh_a(i), d, a, e);
      total++; if ({a, e, d} !== {2'b10, rv[i*DW +: DW]}) begin bad++; $display("FAIL reset_shadow[%0d] ack/err/data=%b%b/%h want=10/%h", i, a, e, d, rv[i*DW +: DW]); end
      bus_read(act_a(i), d, a, e);
      total++; if ({a, e, d} !== {2'b10, rv[i*DW +: DW]}) begin bad++; $display("FAIL reset_active[%0d] ack/err/data=%b%b/%h want=10/%h", i, a, e, d, rv[i*DW +: DW]); end
    end
    @(posedge clk); #1;
    total++; if (sys_ack !== 1'b0) begin bad++; $display("FAIL ack_one_cycle got=%b want=0", sys_ack); end
  endtask

  task automatic test_shadow_write;
    logic [31:0] d;
    logic a, e;
    bus_write(sh_a(2), 32'hAABBCCDD, 4'b0101, 1'b0, a, e);
    bus_read(sh_a(2), d, a, e);
    total++; if (d !== 32'h00BB00DD) begin bad++; $display("FAIL byte_enable got=%h want=00bb00dd", d); end
    total++; if (val !== RST) begin bad++; $display("FAIL val_before_commit got=%h want=%h", val, RST); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL status_pending got=%h want=1", d); end
    bus_write(CTL, 32'h1, 4'hF, 1'b0, a, e);
    total++; if (val[2*DW +: DW] !== 32'h00BB00DD) begin bad++; $display("FAIL commit_val got=%h want=00bb00dd", val[2*DW +: DW]); end
    total++; if (upd_o !== 1'b1) begin bad++; $display("FAIL upd_high got=%b want=1", upd_o); end
    @(posedge clk); #1;
    total++; if (upd_o !== 1'b0) begin bad++; $display("FAIL upd_one_cycle got=%b want=0", upd_o); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL status_after_commit got=%h want=100", d); end
  endtask

  task automatic test_trigger;
    logic [31:0] d;
    logic a, e;
    bus_write(CTL, 32'h2, 4'hF, 1'b0, a, e);
    bus_write(sh_a(0), 32'h5, 4'hF, 1'b0, a, e);
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h103) begin bad++; $display("FAIL armed_status got=%h want=103", d); end
    @(posedge clk); #1 trig_i = 1'b1;
    @(posedge clk); #1 trig_i = 1'b0;
    total++; if (val[DW-1:0] !== 32'h5 || upd_o !== 1'b1) begin bad++; $display("FAIL trig_commit val0/upd=%h/%b want=5/1", val[DW-1:0], upd_o); end
    bus_write(sh_a(0), 32'h7, 4'hF, 1'b0, a, e);
    repeat (8) @(posedge clk);
    #1 trig_i = 1'b1;
    @(posedge clk); #1 trig_i = 1'b0;
    total++; if (val[DW-1:0] !== 32'h5 || upd_o !== 1'b0) begin bad++; $display("FAIL second_trig_ignored val0/upd=%h/%b want=5/0", val[DW-1:0], upd_o); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h201) begin bad++; $display("FAIL status_after_trig got=%h want=201", d); end
  endtask

  task automatic test_pulse;
    logic [31:0] d;
    logic a, e;
    bus_write(sh_a(1), 32'h3, 4'hF, 1'b0, a, e);
    bus_write(CTL, 32'h1, 4'hF, 1'b0, a, e);
    total++; if (val[DW +: DW] !== 32'h3 || val[DW-1:0] !== 32'h7) begin bad++; $display("FAIL pulse_high val1/val0=%h/%h want=3/7", val[DW +: DW], val[DW-1:0]); end
    @(posedge clk); #1;
    total++; if (val[DW +: DW] !== 32'h2) begin bad++; $display("FAIL pulse_cleared got=%h want=2", val[DW +: DW]); end
    bus_read(sh_a(1), d, a, e);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL shadow_pulse_cleared got=%h want=2", d); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL status_after_pulse got=%h want=300", d); end
  endtask

  task automatic test_errors;
    logic [31:0] d;
    logic a, e;
    logic [RN*DW-1:0] exp_val;
    exp_val = {64'h0, 32'hDEADBEEF, 32'h00BB00DD, 32'h2, 32'h7};
    bus_write(act_a(1), 32'hFFFFFFFF, 4'hF, 1'b0, a, e);
    total++; if ({a, e} !== 2'b11) begin bad++; $display("FAIL err_write_active ack/err=%b%b want=11", a, e); end
    bus_read(sh_a(RN), d, a, e);
    total++; if ({a, e, d} !== {2'b11, 32'h0}) begin bad++; $display("FAIL err_index_range ack/err/data=%b%b/%h want=11/0", a, e, d); end
    bus_read(32'h60, d, a, e);
    total++; if ({a, e, d} !== {2'b11, 32'h0}) begin bad++; $display("FAIL err_region3 ack/err/data=%b%b/%h want=11/0", a, e, d); end
    bus_write(CTL | 32'h4, 32'h1, 4'hF, 1'b0, a, e);
    total++; if ({a, e, upd_o} !== 3'b110) begin bad++; $display("FAIL err_ctl_index ack/err/upd=%b%b%b want=110", a, e, upd_o); end
    total++; if (val !== exp_val) begin bad++; $display("FAIL err_state_unchanged got=%h want=%h", val, exp_val); end
    bus_read(act_a(1), d, a, e);
    total++; if ({e, d} !== {1'b0, 32'h2}) begin bad++; $display("FAIL active_read err/data=%b/%h want=0/2", e, d); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL err_no_commit got=%h want=300", d); end
  endtask

  task automatic test_simultaneous;
    logic [31:0] d;
    logic a, e;
    @(posedge clk); #1;
    sys_addr = sh_a(4); sys_wdata = 32'h99; sys_sel = 4'hF; sys_wen = 1'b1; sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_wen = 1'b0; sys_ren = 1'b0;
    total++; if (sys_rdata !== 32'h0) begin bad++; $display("FAIL rw_prewrite got=%h want=0", sys_rdata); end
    bus_read(sh_a(4), d, a, e);
    total++; if (d !== 32'h99) begin bad++; $display("FAIL rw_written got=%h want=99", d); end
    bus_write(CTL, 32'h2, 4'hF, 1'b0, a, e);
    bus_write(sh_a(3), 32'h12345678, 4'hF, 1'b0, a, e);
    bus_write(sh_a(3), 32'hCAFEF00D, 4'hF, 1'b1, a, e);
    total++; if (val[3*DW +: DW] !== 32'h12345678) begin bad++; $display("FAIL write_with_trig_active got=%h want=12345678", val[3*DW +: DW]); end
    bus_read(sh_a(3), d, a, e);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL write_with_trig_shadow got=%h want=cafef00d", d); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h401) begin bad++; $display("FAIL write_with_trig_status got=%h want=401", d); end
    bus_write(CTL, 32'h3, 4'hF, 1'b0, a, e);
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h500 || val[3*DW +: DW] !== 32'hCAFEF00D) begin bad++; $display("FAIL arm_and_commit status/val3=%h/%h want=500/cafef00d", d, val[3*DW +: DW]); end
    bus_write(CTL, 32'h2, 4'hF, 1'b0, a, e);
    bus_write(CTL, 32'h6, 4'hF, 1'b0, a, e);
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h500) begin bad++; $display("FAIL arm_disarm got=%h want=500", d); end
    bus_write(sh_a(3), 32'h1, 4'hF, 1'b0, a, e);
    bus_write(CTL, 32'h8, 4'hF, 1'b0, a, e);
    bus_read(sh_a(3), d, a, e);
    total++; if (d !== 32'hCAFEF00D) begin bad++; $display("FAIL revert_shadow got=%h want=cafef00d", d); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h500) begin bad++; $display("FAIL revert_status got=%h want=500", d); end
    bus_write(sh_a(2), 32'h77, 4'hF, 1'b0, a, e);
    bus_write(CTL, 32'h9, 4'hF, 1'b0, a, e);
    total++; if (val[2*DW +: DW] !== 32'h77) begin bad++; $display("FAIL revert_commit_val got=%h want=77", val[2*DW +: DW]); end
    bus_read(sh_a(2), d, a, e);
    total++; if (d !== 32'h77) begin bad++; $display("FAIL revert_commit_shadow got=%h want=77", d); end
  endtask

  task automatic test_cnt_wrap;
    logic [31:0] d;
    logic a, e;
    for (int n = 0; n < 249; n++) bus_write(CTL, 32'h1, 4'hF, 1'b0, a, e);
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'hFF00) begin bad++; $display("FAIL cnt_255 got=%h want=ff00", d); end
    bus_write(CTL, 32'h1, 4'hF, 1'b0, a, e);
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL cnt_wrap got=%h want=0", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic a, e;
    bus_write(sh_a(0), 32'h55, 4'hF, 1'b0, a, e);
    bus_write(CTL, 32'h1, 4'hF, 1'b0, a, e);
    @(posedge clk); #1;
    sys_addr = sh_a(0); sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_ren = 1'b0;
    total++; if (sys_ack !== 1'b1) begin bad++; $display("FAIL mid_ack_before got=%b want=1", sys_ack); end
    #1 rstn = 1'b0;
    #1;
    total++; if (sys_ack !== 1'b0) begin bad++; $display("FAIL async_ack_drop got=%b want=0", sys_ack); end
    total++; if (val !== RST) begin bad++; $display("FAIL async_val got=%h want=%h", val, RST); end
    @(negedge clk) rstn = 1'b1;
    bus_read(sh_a(0), d, a, e);
    total++; if (d !== 32'h11111111) begin bad++; $display("FAIL reset_shadow0 got=%h want=11111111", d); end
    bus_read(CTL, d, a, e);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", d); end
  endtask

  initial begin
    test_reset;
    test_shadow_write;
    test_trigger;
    test_pulse;
    test_errors;
    test_simultaneous;
    test_cnt_wrap;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
